// File: rtl/axil_master_port.sv
// Single-outstanding AXI4-Lite master driven by the uart2axi_sm command strobe.
// Optional hung-slave watchdog enabled by defining AXIL_TIMEOUT_EN (limit TIMEOUT_CYCLES).
module axil_master_port #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                txn,
  input  logic                rw,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic                axi_busy,
  output logic                rvalid,
  output logic [DATA_W-1:0]   rdata,
  output logic                done,
  output logic [1:0]          resp,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [2:0]          m_axi_awprot,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic [2:0]          m_axi_arprot,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_AW_W = 3'd1,
    WR_B    = 3'd2,
    RD_AR   = 3'd3,
    RD_R    = 3'd4
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                awvalid_q;
  logic                wvalid_q;
  logic                bready_q;
  logic                arvalid_q;
  logic                rready_q;
  logic                busy_q;
  logic                rvalid_q;
  logic                done_q;
  logic [1:0]          resp_q;
  logic [DATA_W-1:0]   rdata_q;

  logic aw_hs, w_hs, aw_ok, w_ok;
  logic timeout;

  assign aw_hs = awvalid_q & m_axi_awready;
  assign w_hs  = wvalid_q & m_axi_wready;
  // A channel is "ok" once its handshake has completed now or earlier.
  assign aw_ok = ~awvalid_q | m_axi_awready;
  assign w_ok  = ~wvalid_q | m_axi_wready;

`ifdef AXIL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             enter;

  // Any transition into a non-IDLE state restarts the watchdog.
  assign enter = ((state_q == IDLE) & txn)
               | ((state_q == WR_AW_W) & aw_ok & w_ok)
               | ((state_q == RD_AR) & m_axi_arready);

  always_ff @(posedge clk) begin
    if (rst || enter) begin
      cnt_q <= '0;
    end else if (state_q != IDLE) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign timeout = (state_q != IDLE) && (cnt_q == CNT_LAST);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      busy_q    <= 1'b0;
      rvalid_q  <= 1'b0;
      done_q    <= 1'b0;
      resp_q    <= 2'b00;
      rdata_q   <= '0;
    end else begin
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
      if (timeout) begin
        awvalid_q <= 1'b0;
        wvalid_q  <= 1'b0;
        bready_q  <= 1'b0;
        arvalid_q <= 1'b0;
        rready_q  <= 1'b0;
        busy_q    <= 1'b0;
        done_q    <= 1'b0 | 1'b1;
        resp_q    <= 2'b11;
        if (state_q == RD_AR || state_q == RD_R) begin
          rvalid_q <= 1'b1;
          rdata_q  <= '0;
        end
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (txn) begin
              addr_q    <= addr;
              wdata_q   <= wdata;
              busy_q    <= 1'b1;
              awvalid_q <= rw;
              wvalid_q  <= rw;
              arvalid_q <= ~rw;
              state_q   <= rw ? WR_AW_W : RD_AR;
            end
          end
          WR_AW_W: begin
            if (aw_hs) awvalid_q <= 1'b0;
            if (w_hs)  wvalid_q  <= 1'b0;
            if (aw_ok && w_ok) begin
              bready_q <= 1'b1;
              state_q  <= WR_B;
            end
          end
          WR_B: begin
            if (m_axi_bvalid) begin
              bready_q <= 1'b0;
              resp_q   <= m_axi_bresp;
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
              state_q  <= IDLE;
            end
          end
          RD_AR: begin
            if (m_axi_arready) begin
              arvalid_q <= 1'b0;
              rready_q  <= 1'b1;
              state_q   <= RD_R;
            end
          end
          RD_R: begin
            if (m_axi_rvalid) begin
              rready_q <= 1'b0;
              rdata_q  <= m_axi_rdata;
              resp_q   <= m_axi_rresp;
              rvalid_q <= 1'b1;
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
              state_q  <= IDLE;
            end
          end
          default: begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end
        endcase
      end
    end
  end

  assign axi_busy      = busy_q;
  assign rvalid        = rvalid_q;
  assign rdata         = rdata_q;
  assign done          = done_q;
  assign resp          = resp_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = '1;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule

// File: doc/axil_master_port.md
Name: axil_master_port

Overview:
- Downstream of uart2axi_sm. Converts its single-word command strobe (txn/rw/addr/wdata) into one AXI4-Lite read or write transaction.
- Returns axi_busy, plus rvalid/rdata on read completion.
- Exactly one transaction outstanding at a time.
- Drives the system AXI4-Lite interconnect as a master.

Parameters:
- ADDR_W, 32, address width (addr, m_axi_awaddr, m_axi_araddr).
- DATA_W, 32, data width; must be 32 or 64.
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with AXIL_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- txn  in  1  command strobe from uart2axi_sm; sampled only in IDLE.
- rw  in  1  1=write, 0=read; sampled with txn.
- addr  in  ADDR_W  byte address; sampled with txn.
- wdata  in  DATA_W  write data; sampled with txn.
- axi_busy  out  1  high while a transaction is in flight.
- rvalid  out  1  one-cycle pulse when read data is valid.
- rdata  out  DATA_W  read data; held until the next read completes.
- done  out  1  one-cycle pulse at completion of any transaction.
- resp  out  2  BRESP/RRESP of the last transaction; 2'b11 on timeout.
- m_axi_awaddr/awprot/awvalid  out  ADDR_W/3/1; awready in 1.
- m_axi_wdata/wstrb/wvalid  out  DATA_W/DATA_W/8/1; wready in 1.
- m_axi_bresp in 2, bvalid in 1; bready out 1.
- m_axi_araddr/arprot/arvalid  out  ADDR_W/3/1; arready in 1.
- m_axi_rdata in DATA_W, rresp in 2, rvalid in 1; rready out 1.

Behaviour:
- Reset (sync, rst=1 at rising edge): state=IDLE; all outputs 0 (all valids/readies, axi_busy, rvalid, done, resp, rdata).
- Reset mid-transaction aborts immediately; all valids drop the next edge.
- Constant outputs: awprot = arprot = 3'b000; wstrb = all ones.
- IDLE, txn=1:
  - Register addr, wdata, rw.
  - axi_busy=1 from the next cycle.
  - Go to WR_AW_W if rw=1, else RD_AR.
- txn while axi_busy=1 is ignored. No queueing.
- WR_AW_W:
  - awvalid and wvalid asserted together.
  - Each deasserts independently the cycle after its own handshake (valid&ready at the edge).
  - When both handshakes are complete (same or different cycles), go to WR_B.
  - AXI rule: valid never drops before ready. Address/data stay stable while valid.
- WR_B:
  - bready=1.
  - On bvalid: resp<=bresp, done pulse, go to IDLE.
- RD_AR:
  - arvalid=1 until arready, then go to RD_R.
- RD_R:
  - rready=1.
  - On rvalid: rdata<=m_axi_rdata, resp<=rresp, rvalid and done pulse, go to IDLE.
- axi_busy = (state != IDLE) as a registered output. It falls in the same cycle the done pulse is high.
- Minimum latency, all slave readies/valids high:
  - Write: txn@T0, aw/w handshake@T1, b handshake@T2, done@T3.
  - Read: ar@T1, r@T2, rvalid/done@T3.
- bvalid/rvalid arriving before bready/rready is asserted are waited on; never lost.
- SLVERR/DECERR are not retried; only reported on resp.

Optional Feature:
- Macro: AXIL_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to any non-IDLE state and increments each cycle in that state.
  - On reaching TIMEOUT_CYCLES: drop all valids/readies, resp=2'b11, done pulse, rvalid pulse with rdata=0 if reading, return to IDLE.
  - Intended for debug fabrics where a hung slave must not lock the UART bridge.
- When undefined: no counter; the master waits indefinitely.

Test Plan:
- Write, slave always ready: txn rw=1 addr=0x0000_1000 wdata=0xDEADBEEF -> awaddr=0x1000, wdata=0xDEADBEEF, wstrb=0xF at T1; done@T3; resp=00; axi_busy high T1-T2.
- Write with skewed readies: awready delayed 3 cycles, wready immediate -> wvalid drops after T1, awvalid held to T4; bready only after both handshakes; single done.
- Read: addr=0x20, slave returns 0x12345678 with rresp=00 after 5 wait cycles -> rvalid pulse of exactly 1 cycle; rdata=0x12345678 held afterward.
- Error and busy-ignore: read returning rresp=2'b10 -> resp=10. A txn pulsed while axi_busy=1 -> no second AR issued.
- Reset mid-write: rst at T2 with awvalid pending -> next cycle all valids=0, axi_busy=0. A new read then completes normally.
- AXIL_TIMEOUT_EN, TIMEOUT_CYCLES=16, arready stuck low -> after 16 cycles arvalid=0, resp=11, rvalid/done pulse, rdata=0.
